// File: rtl/cic_comb_chain.sv
// CIC comb section: N_STAGES cascaded y[n] = x[n] - x[n-M] stages with per-channel history,
// one pipeline register and one bit of growth per stage, valid/ready with full backpressure.
module cic_comb_chain #(
  parameter int IN_W       = 16,
  parameter int N_STAGES   = 3,
  parameter int DIFF_DELAY = 1,
  parameter int NUM_CH     = 1,
  parameter int CH_W       = 3,
  localparam int OUT_W     = IN_W + N_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]         in_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]         out_chan
);

  logic advance;
  logic clear;

  // Index 0 is the accepted input; index k is the register of stage k.
  logic [N_STAGES:0]        stg_valid;
  logic signed [OUT_W-1:0]  stg_data [N_STAGES+1];
  logic [CH_W-1:0]          stg_chan [N_STAGES+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush && !rst;
  assign clear    = rst || flush;

  // Out-of-range tags are accepted but enter the pipeline as a bubble.
  assign stg_valid[0] = in_valid && in_ready && (int'(in_chan) < NUM_CH);
  assign stg_data[0]  = OUT_W'(in_data);
  assign stg_chan[0]  = in_chan;

  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : gen_stage
      localparam int XW = IN_W + gi;
      localparam int YW = XW + 1;

      logic signed [XW-1:0]       x;
      logic [OUT_W-XW-1:0]        unused_hi;
      logic signed [XW-1:0]       hist_q [2**CH_W][DIFF_DELAY];
      logic signed [YW-1:0]       y_d;
      logic signed [YW-1:0]       y_q;
      logic                       v_q;
      logic [CH_W-1:0]            ch_q;

      // The carried value always fits in XW bits; the upper bits are pure sign extension.
      assign x         = stg_data[gi][XW-1:0];
      assign unused_hi = stg_data[gi][OUT_W-1:XW];
      assign y_d       = YW'(x) - YW'(hist_q[stg_chan[gi]][DIFF_DELAY-1]);

      always_ff @(posedge clk) begin
        if (clear) begin
          v_q  <= 1'b0;
          y_q  <= '0;
          ch_q <= '0;
          for (int c = 0; c < 2**CH_W; c++) begin
            for (int j = 0; j < DIFF_DELAY; j++) begin
              hist_q[c][j] <= '0;
            end
          end
        end else if (advance) begin
          v_q <= stg_valid[gi];
          if (stg_valid[gi]) begin
            y_q  <= y_d;
            ch_q <= stg_chan[gi];
            hist_q[stg_chan[gi]][0] <= x;
            for (int j = 1; j < DIFF_DELAY; j++) begin
              hist_q[stg_chan[gi]][j] <= hist_q[stg_chan[gi]][j-1];
            end
          end
        end
      end

      assign stg_valid[gi+1] = v_q;
      assign stg_data[gi+1]  = OUT_W'(y_q);
      assign stg_chan[gi+1]  = ch_q;
    end
  endgenerate

  assign out_valid = stg_valid[N_STAGES];
  assign out_data  = stg_data[N_STAGES];
  assign out_chan  = stg_chan[N_STAGES];

endmodule

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
- Parametrised comb section for the CIC interpolation path.
- Cascades N_STAGES comb stages, each computing y[n] = x[n] - x[n-DIFF_DELAY]. Each stage adds one register of pipelining and one bit of width growth.
- Supports NUM_CH time-multiplexed channels with independent history per channel.
- Uses valid/ready handshake with full backpressure. Sits between the sample source and the upsampler/integrator section.

Parameters:
- IN_W, 16, input sample width, two's complement
- N_STAGES, 3, number of cascaded comb stages (1..8)
- DIFF_DELAY, 1, differential delay M (1 or 2)
- NUM_CH, 1, number of TDM channels (1..8)
- CH_W, 3, channel tag width; must satisfy 2^CH_W >= NUM_CH, minimum 1
- OUT_W, IN_W+N_STAGES, output width (derived, not overridable)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- flush, input, 1, synchronous clear of all history and pipeline, without reset
- in_valid, input, 1, input sample valid
- in_ready, output, 1, block accepts sample this cycle
- in_data, input, IN_W, signed input sample
- in_chan, input, CH_W, channel index of in_data
- out_valid, output, 1, output sample valid
- out_ready, input, 1, downstream accepts
- out_data, output, OUT_W, signed comb output
- out_chan, output, CH_W, channel tag travelling with out_data

Behaviour:
- Reset is synchronous and active-high, on clock clk. On rst: out_valid=0, out_data=0, out_chan=0, all stage valid bits 0, all history registers 0. in_ready is 0 during the rst cycle.
- advance = !out_valid || out_ready. in_ready = advance && !flush && !rst.
- Accept: in_valid && in_ready.
- On advance, every stage register loads from its predecessor, with bubbles propagating as valid=0.
- When advance=0, the whole pipeline holds. out_data and out_chan must stay stable while out_valid && !out_ready.
- Latency: N_STAGES cycles from accept to out_valid when unstalled. Throughput is 1 sample/clk.
- Stage k (1..N_STAGES):
  - Input width IN_W+k-1, output width IN_W+k.
  - Operands are sign-extended before subtraction; no saturation and no overflow is possible.
  - Result = x - hist[k][chan][DIFF_DELAY-1].
- History update happens only when a valid sample passes through stage k, and only for that sample's channel:
  - Shift the per-channel delay line (depth DIFF_DELAY).
  - hist[k][chan][0] takes the stage input x.
- Bubbles and other channels' samples never modify a channel's history.
- The channel tag is registered alongside data in every stage.
- Channel ordering is arbitrary: no round-robin is required, and consecutive samples of the same channel are allowed.
- in_chan >= NUM_CH while accepted: the sample is dropped (not forwarded) and no history is modified. in_ready is unaffected.
- Start-up: the first DIFF_DELAY samples of each channel see zero history, so stage output equals stage input.
- flush=1:
  - Next cycle, all stage valids and history are 0 and out_valid=0.
  - No sample is accepted in the flush cycle.
  - flush overrides out_ready; any pending output is discarded.
- rst overrides flush. rst mid-stream discards all in-flight samples, identical to power-on.
- Simultaneous out_ready and an in_valid accept keeps a full pipeline streaming with no bubble.

Test Plan:
1. N_STAGES=3, M=1, C=1; impulse 100 then zeros, out_ready=1 -> out_data sequence 100, -300, 300, -100, 0, 0…. First out_valid exactly 3 cycles after accept.
2. N_STAGES=3, M=1; constant 5 -> 5, -10, 5, 0, 0…. Repeat after flush -> the same sequence restarts from 5.
3. N_STAGES=1, IN_W=16; alternate 32767, -32768 -> 32767, -65535, 65535, -65535… exact in 17 bits, no wrap.
4. N_STAGES=1, M=2, C=2; interleave ch0 {10,0,0,0} with ch1 {7,7,7,7} -> ch0 outputs 10, 0, -10, 0; ch1 outputs 7, 7, 0, 0; out_chan matches input tags.
5. Stream 20 samples; drop out_ready for 5 cycles mid-stream -> in_ready=0 during the stall, out_data/out_chan held stable, no sample lost or duplicated versus the golden model.
6. Assert rst with 3 samples in flight -> out_valid=0 next cycle. The next impulse of 100 reproduces scenario 1 exactly. Also send in_chan=NUM_CH -> no output and no history change.
